data_memory_rsp: RTL

Memory-side responder for the MIF request/stall handshake that the data cache drives.
- Holds a word-organised RAM and serves single byte/half/word reads and writes after a programmable latency.
- Lets the cache line-fill engine and the write-through path be exercised against realistic wait states.
- Exposes a memory-mapped LED bit on dm_led_o.
- Sits between cache_rw's MIF_* outputs and the board-level memory/LED.

---
 rtl/data_memory_rsp_pkg.sv | 25 ++
 rtl/mem_lane_align.sv | 54 +++++
 rtl/data_memory_rsp.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/data_memory_rsp_pkg.sv
// Shared types and constants for the data-memory responder and its lane aligner.
// Holds the bus widths, memory-mode encodings, FSM state type and the
// latency-counter width used by data_memory_rsp and mem_lane_align.
package data_memory_rsp_pkg;

    localparam int unsigned AluOpSize   = 32;  // byte address width
    localparam int unsigned GprSize     = 32;  // write data width
    localparam int unsigned MemDataSize = 32;  // read data / RAM word width
    localparam int unsigned MemModeSize = 2;
    localparam int unsigned DmrLatBits  = 4;   // latency counter, LATENCY in 0..15

    localparam logic [MemModeSize-1:0] MemModeByte = 2'd0;
    localparam logic [MemModeSize-1:0] MemModeHalf = 2'd1;
    localparam logic [MemModeSize-1:0] MemModeWord = 2'd2;

    // Marker value returned for a read with an undefined mem_mode.
    localparam logic [MemDataSize-1:0] UndefReadData = 32'd123;

    typedef enum logic [1:0] {
        DmrIdle = 2'd0,
        DmrBusy = 2'd1,
        DmrDone = 2'd2
    } dmr_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte/half/word lane logic shared by memory-side paths.
//   lane_i       : low two address bits (byte lane; bit 1 selects the half lane)
//   mem_mode_i   : MemModeByte / MemModeHalf / MemModeWord
//   sign_i       : 1 = zero-extend read, 0 = sign-extend read
//   wdata_i      : right-justified write data
//   word_i       : current contents of the addressed word
//   merged_o     : word_i with the selected lane(s) replaced by wdata_i
//   rdata_o      : extracted and extended read value (UndefReadData on bad mode)
//   mode_valid_o : mem_mode_i is one of the defined encodings
module mem_lane_align
    import data_memory_rsp_pkg::*;
(
    input  logic [1:0]             lane_i,
    input  logic [MemModeSize-1:0] mem_mode_i,
    input  logic                   sign_i,
    input  logic [GprSize-1:0]     wdata_i,
    input  logic [MemDataSize-1:0] word_i,
    output logic [MemDataSize-1:0] merged_o,
    output logic [MemDataSize-1:0] rdata_o,
    output logic                   mode_valid_o
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        // Misaligned half/word accesses are aligned down by ignoring low bits.
        byte_sh      = {lane_i, 3'b000};
        half_sh      = {lane_i[1], 4'b0000};
        rd_byte      = word_i[byte_sh +: 8];
        rd_half      = word_i[half_sh +: 16];
        merged_o     = word_i;
        rdata_o      = UndefReadData;
        mode_valid_o = 1'b1;
        case (mem_mode_i)
            MemModeByte: begin
                merged_o[byte_sh +: 8] = wdata_i[7:0];
                rdata_o = sign_i ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            end
            MemModeHalf: begin
                merged_o[half_sh +: 16] = wdata_i[15:0];
                rdata_o = sign_i ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
            end
            MemModeWord: begin
                merged_o = wdata_i;
                rdata_o  = word_i;
            end
            default: mode_valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/data_memory_rsp.sv
// Memory-side responder for the cache MIF request/stall handshake.
// Serves one byte/half/word read or write per request after LATENCY wait
// cycles, and decodes one word address as a 1-bit LED register.
//   clock_i      : clock (rising edge)
//   reset_n_i    : asynchronous active-low reset
//   address_i    : byte address
//   data_i       : right-justified write data
//   write_data_i : write request (wins over read)
//   read_data_i  : read request
//   sign_i       : 1 = zero-extend, 0 = sign-extend byte/half reads
//   mem_mode_i   : access size
//   read_data_o  : last completed read result
//   stall_o      : request not yet complete
//   dm_led_o     : LED register bit 0
module data_memory_rsp
    import data_memory_rsp_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 3,
    parameter logic [31:0] LED_ADDR   = 32'hFFFF_FFF0,
    parameter string       INIT_FILE  = ""
) (
    input  logic                   clock_i,
    input  logic                   reset_n_i,
    input  logic [AluOpSize-1:0]   address_i,
    input  logic [GprSize-1:0]     data_i,
    input  logic                   write_data_i,
    input  logic                   read_data_i,
    input  logic                   sign_i,
    input  logic [MemModeSize-1:0] mem_mode_i,
    output logic [MemDataSize-1:0] read_data_o,
    output logic                   stall_o,
    output logic                   dm_led_o
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;
    localparam logic [DmrLatBits-1:0] LatCnt = DmrLatBits'(LATENCY);

    logic [MemDataSize-1:0] mem_q [Depth];

    dmr_state_e             state_q;
    logic [DmrLatBits-1:0]  cnt_q;
    logic [AluOpSize-1:0]   addr_q;
    logic [GprSize-1:0]     wdata_q;
    logic [MemModeSize-1:0] mode_q;
    logic                   sign_q;
    logic                   write_q;
    logic [MemDataSize-1:0] read_data_q;
    logic                   led_q;

    logic                   in_req;
    logic [AluOpSize-1:0]   op_addr;
    logic [GprSize-1:0]     op_wdata;
    logic [MemModeSize-1:0] op_mode;
    logic                   op_sign;
    logic                   op_write;
    logic                   do_op;
    logic                   is_led;
    logic [DEPTH_LOG2-1:0]  mem_idx;
    logic [MemDataSize-1:0] mem_word;
    logic [MemDataSize-1:0] merged;
    logic [MemDataSize-1:0] align_rdata;
    logic                   mode_valid;
    logic                   mem_we;
    logic [MemDataSize-1:0] rd_result;

    always_comb begin
        in_req = read_data_i | write_data_i;
        // With zero latency the operation happens on the accepting edge, so
        // it must use the live inputs rather than the latched copy.
        if (state_q == DmrIdle) begin
            op_addr  = address_i;
            op_wdata = data_i;
            op_mode  = mem_mode_i;
            op_sign  = sign_i;
            op_write = write_data_i;
        end else begin
            op_addr  = addr_q;
            op_wdata = wdata_q;
            op_mode  = mode_q;
            op_sign  = sign_q;
            op_write = write_q;
        end
        do_op = ((state_q == DmrIdle) && in_req && (LatCnt == '0)) ||
                ((state_q == DmrBusy) && (cnt_q == DmrLatBits'(1)));
        is_led  = (op_addr[AluOpSize-1:2] == LED_ADDR[31:2]);
        mem_idx = op_addr[DEPTH_LOG2+1:2];
    end

    assign mem_word = mem_q[mem_idx];

    mem_lane_align u_lane_align (
        .lane_i       (op_addr[1:0]),
        .mem_mode_i   (op_mode),
        .sign_i       (op_sign),
        .wdata_i      (op_wdata),
        .word_i       (mem_word),
        .merged_o     (merged),
        .rdata_o      (align_rdata),
        .mode_valid_o (mode_valid)
    );

    always_comb begin
        // Gating with reset keeps an abandoned write out of the RAM.
        mem_we    = reset_n_i & do_op & op_write & mode_valid & ~is_led;
        rd_result = is_led ? {31'b0, led_q} : align_rdata;
        case (state_q)
            DmrIdle: stall_o = in_req;
            DmrBusy: stall_o = 1'b1;
            default: stall_o = 1'b0;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= DmrIdle;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mode_q      <= '0;
            sign_q      <= 1'b0;
            write_q     <= 1'b0;
            read_data_q <= '0;
            led_q       <= 1'b0;
        end else begin
            unique case (state_q)
                DmrIdle: begin
                    if (in_req) begin
                        addr_q  <= address_i;
                        wdata_q <= data_i;
                        mode_q  <= mem_mode_i;
                        sign_q  <= sign_i;
                        write_q <= write_data_i;
                        cnt_q   <= LatCnt;
                        state_q <= (LatCnt == '0) ? DmrDone : DmrBusy;
                    end
                end
                DmrBusy: begin
                    cnt_q <= cnt_q - DmrLatBits'(1);
                    if (cnt_q == DmrLatBits'(1)) begin
                        state_q <= DmrDone;
                    end
                end
                // Requests are not sampled here so a stale address is not re-served.
                DmrDone: state_q <= DmrIdle;
                default: state_q <= DmrIdle;
            endcase
            if (do_op && !op_write) begin
                read_data_q <= rd_result;
            end
            if (do_op && op_write && is_led && mode_valid) begin
                led_q <= op_wdata[0];
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (mem_we) begin
            mem_q[mem_idx] <= merged;
        end
    end

    assign read_data_o = read_data_q;
    assign dm_led_o    = led_q;

endmodule
